dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sits directly downstream of the integer mem_stage and the FPU mem stage.
- Arbitrates their load/store requests onto one single-ported, variable-latency data-memory bus and returns read data and done/error pulses to each requester.
- Drives mem_stall back into the pipeline while any request is outstanding.
- Enforces word alignment and guards against a hung memory with a timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 16, max cycles in a BUSY state without mem_ready before aborting with error (range 2..255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
int_req  input  1  integer-pipe request valid; held until int_done
int_we  input  1  1=store, 0=load
int_addr  input  ADDR_W  integer byte address
int_wdata  input  DATA_W  integer store data
fp_req  input  1  FPU request valid; held until fp_done
fp_we  input  1  1=store (FSW), 0=load (FLW)
fp_addr  input  ADDR_W  FPU byte address
fp_wdata  input  DATA_W  FPU store data
mem_req  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_ready  input  1  memory completes the access this cycle
mem_rdata  input  DATA_W  memory read data, valid with mem_ready
int_rdata  output  DATA_W  integer load data
int_done  output  1  one-cycle completion pulse to integer pipe
int_err  output  1  valid with int_done: misaligned or timeout
fp_rdata  output  DATA_W  FPU load data
fp_done  output  1  one-cycle completion pulse to FPU pipe
fp_err  output  1  valid with fp_done
mem_stall  output  1  stall both pipes

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE and the round-robin pointer goes to INT.
  - All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, rdata, done, err, mem_stall. The timeout counter is 0.
  - Reset asserted mid-access drops mem_req immediately. The in-flight access is abandoned and no done pulse is produced.
- States: IDLE, BUSY_INT, BUSY_FP, RESP_INT, RESP_FP.
- IDLE:
  - Only int_req → latch int_we/addr/wdata.
  - Only fp_req → latch the fp fields.
  - Both → grant the side named by the pointer. The pointer then flips to the other side, so a stream of simultaneous requests alternates INT, FP, INT, and so on.
  - Granted address with addr[1:0]!=0 → go to RESP_x with err=1 and rdata=0. No memory access is made.
  - Otherwise → go to BUSY_x and clear the counter.
- BUSY_x:
  - mem_req=1; mem_we/addr/wdata come from the latched registers and stay stable for the whole state.
  - mem_ready=1 → for a load, latch mem_rdata into x_rdata; for a store, x_rdata is unchanged. Go to RESP_x with err=0.
  - mem_ready=0 → counter increments. When the counter reaches TIMEOUT-1 without mem_ready → go to RESP_x with err=1 and x_rdata=0.
  - mem_ready seen in the same cycle as the timeout boundary counts as success.
- RESP_x:
  - x_done=1 for exactly one cycle, with x_err and x_rdata valid. Next state is IDLE.
  - x_rdata holds its value until the next load completes on that side.
- Requester rule: deassert req at the edge ending the done cycle. Requests are never sampled in BUSY or RESP, so a losing requester waits, holding its fields, and is served from IDLE afterwards.
- Latency with a zero-wait memory (mem_ready in the first BUSY cycle):
  - Request in IDLE cycle N → BUSY at N+1 → done at N+2.
  - Misaligned request: done at N+1.
  - Timeout: done at N+1+TIMEOUT.
- mem_stall = (int_req & ~int_done) | (fp_req & ~fp_done). This is combinational.
- Signals outside BUSY:
  - mem_req is registered from the state and is 1 only in BUSY states.
  - mem_we is 0 whenever mem_req=0.
  - mem_addr/mem_wdata keep their last value.
- Addresses pass through unmodified. The memory is responsible for word indexing.

Test Plan:
- Integer load: int_req=1, int_addr=0x40, memory returns 0x12345678 with zero wait → mem_req high in cycle 1, int_done in cycle 2, int_rdata=0x12345678, int_err=0, mem_stall high in cycles 0–1 and low in cycle 2.
- Simultaneous requests after reset: int store to 0x10 and fp load from 0x20 → INT served first (mem_we=1, addr 0x10), FP served next (addr 0x20). A second simultaneous pair is served FP first (pointer flipped); fp_done and int_done never assert in the same cycle.
- Wait states: fp load with mem_ready delayed 5 cycles, mem_rdata=0x3F800000 → fp_done 7 cycles after the request, fp_rdata=0x3F800000, mem_addr and mem_we stable throughout BUSY.
- Misaligned: int_addr=0x42 → no mem_req at all, int_done one cycle later with int_err=1 and int_rdata=0.
- Timeout: TIMEOUT=16, fp store with mem_ready held at 0 → fp_done with fp_err=1 at cycle 17; a later integer request is served normally.
- Reset mid-access: rst=0 during BUSY_INT → mem_req=0 immediately and no int_done. After release, a fresh int_req completes normally and the pointer is back at INT.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one variable-latency data-memory port
// between the integer and FPU mem stages, with timeout and alignment guard.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_req,
  input  logic              int_we,
  input  logic [ADDR_W-1:0] int_addr,
  input  logic [DATA_W-1:0] int_wdata,
  input  logic              fp_req,
  input  logic              fp_we,
  input  logic [ADDR_W-1:0] fp_addr,
  input  logic [DATA_W-1:0] fp_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] int_rdata,
  output logic              int_done,
  output logic              int_err,
  output logic [DATA_W-1:0] fp_rdata,
  output logic              fp_done,
  output logic              fp_err,
  output logic              mem_stall
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_INT,
    BUSY_FP,
    RESP_INT,
    RESP_FP
  } state_t;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] frdata_q, frdata_d;

  logic              gnt_fp;
  logic              gnt_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;

  // pick the winning side and its request fields
  always_comb begin
    gnt_fp    = fp_req & (~int_req | ptr_q);
    gnt_we    = gnt_fp ? fp_we : int_we;
    gnt_addr  = gnt_fp ? fp_addr : int_addr;
    gnt_wdata = gnt_fp ? fp_wdata : int_wdata;
  end

  // next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    req_d    = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    irdata_d = irdata_q;
    frdata_d = frdata_q;
    unique case (state_q)
      IDLE: begin
        if (int_req | fp_req) begin
          if (int_req & fp_req) ptr_d = ~ptr_q;
          if (gnt_addr[1:0] != 2'b00) begin
            state_d = gnt_fp ? RESP_FP : RESP_INT;
            err_d   = 1'b1;
            if (gnt_fp) frdata_d = '0;
            else        irdata_d = '0;
          end else begin
            state_d = gnt_fp ? BUSY_FP : BUSY_INT;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = gnt_we;
            addr_d  = gnt_addr;
            wdata_d = gnt_wdata;
          end
        end
      end
      BUSY_INT, BUSY_FP: begin
        if (mem_ready) begin
          state_d = (state_q == BUSY_FP) ? RESP_FP : RESP_INT;
          err_d   = 1'b0;
          if (!we_q) begin
            if (state_q == BUSY_FP) frdata_d = mem_rdata;
            else                    irdata_d = mem_rdata;
          end
        end else if (cnt_q == CntLast) begin
          state_d = (state_q == BUSY_FP) ? RESP_FP : RESP_INT;
          err_d   = 1'b1;
          if (state_q == BUSY_FP) frdata_d = '0;
          else                    irdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          req_d = 1'b1;
        end
      end
      RESP_INT, RESP_FP: state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      irdata_q <= '0;
      frdata_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      irdata_q <= irdata_d;
      frdata_q <= frdata_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = req_q & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign int_done  = (state_q == RESP_INT);
  assign fp_done   = (state_q == RESP_FP);
  assign int_err   = int_done & err_q;
  assign fp_err    = fp_done & err_q;
  assign int_rdata = irdata_q;
  assign fp_rdata  = frdata_q;
  assign mem_stall = (int_req & ~int_done) | (fp_req & ~fp_done);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed + random checks of dmem_arbiter
// against a transaction-level model of grant, latency and results.
module tb_dmem_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        int_req = 1'b0, int_we = 1'b0;
  logic [31:0] int_addr = '0, int_wdata = '0;
  logic        fp_req = 1'b0, fp_we = 1'b0;
  logic [31:0] fp_addr = '0, fp_wdata = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] int_rdata, fp_rdata;
  logic        int_done, int_err, fp_done, fp_err, mem_stall;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .int_req(int_req), .int_we(int_we),
    .int_addr(int_addr), .int_wdata(int_wdata),
    .fp_req(fp_req), .fp_we(fp_we),
    .fp_addr(fp_addr), .fp_wdata(fp_wdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .int_rdata(int_rdata), .int_done(int_done), .int_err(int_err),
    .fp_rdata(fp_rdata), .fp_done(fp_done), .fp_err(fp_err),
    .mem_stall(mem_stall)
  );

  // transaction-level model
  int          cyc = 0;
  int          done_at = -1;
  int          busy_lo = 1, busy_hi = 0;
  bit          side_fp = 0;
  bit          ptr_fp = 0;
  bit          exp_err = 0;
  bit          pend_we = 0;
  logic [31:0] pend_addr = '0, pend_wdata = '0, pend_rd = '0;
  logic [31:0] exp_rd [2];
  int          wait_n = 0, mcnt = 0;
  logic [31:0] ld_data = '0;
  int          next_wait = 0;
  logic [31:0] next_data = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic grant();
    bit f;
    if (int_req && fp_req) begin
      f = ptr_fp;
      ptr_fp = !ptr_fp;
    end else begin
      f = fp_req;
    end
    side_fp    = f;
    pend_addr  = f ? fp_addr : int_addr;
    pend_we    = f ? fp_we : int_we;
    pend_wdata = f ? fp_wdata : int_wdata;
    wait_n     = next_wait;
    ld_data    = next_data;
    mcnt       = 0;
    if (pend_addr[1:0] != 2'b00) begin
      done_at = cyc + 1;
      busy_lo = cyc + 1;
      busy_hi = cyc;
      exp_err = 1;
      pend_rd = '0;
    end else begin
      busy_lo = cyc + 1;
      if (wait_n <= TO - 1) begin
        done_at = cyc + 2 + wait_n;
        exp_err = 0;
        pend_rd = pend_we ? exp_rd[f] : ld_data;
      end else begin
        done_at = cyc + 1 + TO;
        exp_err = 1;
        pend_rd = '0;
      end
      busy_hi = done_at - 1;
    end
  endtask

  task automatic step();
    bit eb, edi, edf;
    if (cyc > done_at && (int_req || fp_req)) grant();
    if (mem_req) begin
      mem_ready = (mcnt == wait_n);
      mem_rdata = mem_ready ? ld_data : $urandom;
      mcnt++;
    end else begin
      mcnt = 0;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    #1;
    eb  = (cyc >= busy_lo) && (cyc <= busy_hi);
    edi = (cyc == done_at) && !side_fp;
    edf = (cyc == done_at) && side_fp;
    if (cyc == done_at) exp_rd[side_fp] = pend_rd;
    chk("mem_req", 32'(mem_req), 32'(eb));
    chk("mem_we", 32'(mem_we), 32'(eb & pend_we));
    if (eb) begin
      chk("mem_addr", mem_addr, pend_addr);
      chk("mem_wdata", mem_wdata, pend_wdata);
    end
    chk("int_done", 32'(int_done), 32'(edi));
    chk("fp_done", 32'(fp_done), 32'(edf));
    if (edi) chk("int_err", 32'(int_err), 32'(exp_err));
    if (edf) chk("fp_err", 32'(fp_err), 32'(exp_err));
    chk("int_rdata", int_rdata, exp_rd[0]);
    chk("fp_rdata", fp_rdata, exp_rd[1]);
    chk("mem_stall", 32'(mem_stall),
        32'((int_req & !edi) | (fp_req & !edf)));
    @(posedge clk);
    #1;
    cyc++;
    if (done_at == cyc - 1) begin
      if (side_fp) fp_req = 1'b0;
      else         int_req = 1'b0;
    end
  endtask

  task automatic drain(int lim);
    int n = 0;
    while ((int_req || fp_req || cyc <= done_at) && n < lim) begin
      step();
      n++;
    end
    chk("drain_bound", 32'(n < lim), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    int_req = 1'b0;
    fp_req = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_int_done", 32'(int_done), 32'd0);
    chk("rst_fp_done", 32'(fp_done), 32'd0);
    chk("rst_int_err", 32'(int_err), 32'd0);
    chk("rst_fp_err", 32'(fp_err), 32'd0);
    chk("rst_int_rdata", int_rdata, 32'd0);
    chk("rst_fp_rdata", fp_rdata, 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    done_at = -1;
    busy_lo = 1;
    busy_hi = 0;
    ptr_fp = 0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    mcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic req_int(bit we, logic [31:0] a, logic [31:0] d);
    int_req = 1'b1;
    int_we = we;
    int_addr = a;
    int_wdata = d;
  endtask

  task automatic req_fp(bit we, logic [31:0] a, logic [31:0] d);
    fp_req = 1'b1;
    fp_we = we;
    fp_addr = a;
    fp_wdata = d;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    else a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    int g;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    #2;
    do_reset();

    // integer load, zero wait
    next_wait = 0;
    next_data = 32'h12345678;
    req_int(0, 32'h40, 32'h0);
    drain(20);
    chk("t1_int_rdata", int_rdata, 32'h12345678);

    // simultaneous pairs
    next_data = 32'hA5A5_0001;
    req_int(1, 32'h10, 32'hCAFE_0010);
    req_fp(0, 32'h20, 32'h0);
    drain(20);
    chk("t2_fp_rdata", fp_rdata, 32'hA5A5_0001);
    next_data = 32'hA5A5_0002;
    req_int(0, 32'h14, 32'h0);
    req_fp(1, 32'h24, 32'hBEEF_0024);
    step();
    chk("t2_ptr_fp_first", 32'(side_fp), 32'd1);
    drain(20);

    // fp load with five wait states
    next_wait = 5;
    next_data = 32'h3F80_0000;
    req_fp(0, 32'h80, 32'h0);
    g = cyc;
    drain(30);
    chk("t3_fp_done_lat", 32'(done_at - g), 32'd7);
    chk("t3_fp_rdata", fp_rdata, 32'h3F80_0000);

    // misaligned
    req_int(0, 32'h42, 32'h0);
    g = cyc;
    drain(10);
    chk("t4_misal_lat", 32'(done_at - g), 32'd1);
    chk("t4_int_rdata", int_rdata, 32'h0);

    // timeout on fp store, then normal integer access
    next_wait = 1000;
    req_fp(1, 32'h100, 32'h1111_2222);
    g = cyc;
    drain(40);
    chk("t5_to_lat", 32'(done_at - g), 32'(TO + 1));
    next_wait = 0;
    next_data = 32'h0BAD_F00D;
    req_int(0, 32'h104, 32'h0);
    drain(10);
    chk("t5_int_rdata", int_rdata, 32'h0BAD_F00D);

    // ready exactly at timeout boundary counts as success
    next_wait = TO - 1;
    next_data = 32'h5555_AAAA;
    req_int(0, 32'h200, 32'h0);
    drain(40);
    chk("t6_edge_rdata", int_rdata, 32'h5555_AAAA);
    next_wait = TO;
    req_int(0, 32'h204, 32'h0);
    drain(40);
    chk("t6_over_rdata", int_rdata, 32'h0);

    // reset mid-access, then pointer back at INT
    next_wait = 10;
    req_int(0, 32'h300, 32'h0);
    step();
    step();
    step();
    do_reset();
    next_wait = 0;
    next_data = 32'h7777_0001;
    req_int(0, 32'h304, 32'h0);
    req_fp(0, 32'h308, 32'h0);
    step();
    chk("t7_ptr_int_first", 32'(side_fp), 32'd0);
    drain(20);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      if (!int_req && $urandom_range(0, 2) == 0)
        req_int(1'($urandom_range(0, 1)), rand_addr(), $urandom);
      if (!fp_req && $urandom_range(0, 2) == 0)
        req_fp(1'($urandom_range(0, 1)), rand_addr(), $urandom);
      r = $urandom_range(0, 9);
      next_wait = (r == 9) ? $urandom_range(TO - 2, TO + 2) : r;
      next_data = $urandom;
      step();
    end
    drain(100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
